// File: rtl/taus88_stream.sv
// taus88 (L'Ecuyer) three-component Tausworthe generator with run-time seeding,
// warm-up discard, NUM_WORDS-wide output packing and a valid/ready output.
module taus88_stream #(
    parameter int          NUM_WORDS = 1,
    parameter int          WARMUP    = 16,
    parameter logic [31:0] SEED1     = 32'hE761B9DB,
    parameter logic [31:0] SEED2     = 32'hB4B4D15C,
    parameter logic [31:0] SEED3     = 32'hC0B4DD55
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      seed_valid,
    input  logic [95:0]               seed_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [32*NUM_WORDS-1:0]   out_data,
    output logic                      busy
);

    localparam int              OUT_W      = 32 * NUM_WORDS;
    localparam int              KW         = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [KW-1:0]   K_LAST     = KW'(NUM_WORDS - 1);
    localparam logic [15:0]     WU_LAST    = 16'(WARMUP - 1);
    localparam logic [0:0]      ST_WARMUP  = 1'b0;
    localparam logic [0:0]      ST_RUN     = 1'b1;
    localparam logic [0:0]      ST_LOAD    = (WARMUP > 0) ? ST_WARMUP : ST_RUN;
    localparam logic [95:0]     RESET_SEED = {SEED3, SEED2, SEED1};

    // All-zero low bits would lock a component into a degenerate short cycle.
    function automatic logic [95:0] sanitise(input logic [95:0] sd);
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] s3;
        s1 = sd[31:0];
        s2 = sd[63:32];
        s3 = sd[95:64];
        if (s1 < 32'd2) begin
            s1 = s1 | 32'd2;
        end else begin
            s1 = s1;
        end
        if (s2 < 32'd8) begin
            s2 = s2 | 32'd8;
        end else begin
            s2 = s2;
        end
        if (s3 < 32'd16) begin
            s3 = s3 | 32'd16;
        end else begin
            s3 = s3;
        end
        return {s3, s2, s1};
    endfunction

    function automatic logic [95:0] taus_step(input logic [95:0] st);
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] s3;
        s1 = st[31:0];
        s2 = st[63:32];
        s3 = st[95:64];
        s1 = ((s1 & 32'hFFFFFFFE) << 12) ^ (((s1 << 13) ^ s1) >> 19);
        s2 = ((s2 & 32'hFFFFFFF8) << 4)  ^ (((s2 << 2)  ^ s2) >> 25);
        s3 = ((s3 & 32'hFFFFFFF0) << 17) ^ (((s3 << 3)  ^ s3) >> 11);
        return {s3, s2, s1};
    endfunction

    logic [0:0]       state_r;
    logic [95:0]      s_r;
    logic [OUT_W-1:0] asm_r;
    logic [KW-1:0]    k_r;
    logic [15:0]      wcnt_r;
    logic             out_valid_r;
    logic [OUT_W-1:0] out_data_r;
    logic             busy_r;

    logic [95:0]      nxt_s;
    logic [31:0]      word_s;
    logic [OUT_W-1:0] beat_s;

    // Next generator state, its output word, and the assembly with slot k filled.
    always_comb begin
        nxt_s  = taus_step(s_r);
        word_s = nxt_s[95:64] ^ nxt_s[63:32] ^ nxt_s[31:0];
        beat_s = asm_r;
        beat_s[{k_r, 5'b00000} +: 32] = word_s;
    end

    // Load/warm-up/run sequencing; a load (reset or seed) overrides everything.
    always_ff @(posedge clk) begin
        if (rst || seed_valid) begin
            s_r         <= sanitise(rst ? RESET_SEED : seed_data);
            state_r     <= ST_LOAD;
            busy_r      <= (ST_LOAD == ST_WARMUP);
            asm_r       <= '0;
            k_r         <= '0;
            wcnt_r      <= 16'd0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else begin
            case (state_r)
                ST_WARMUP: begin
                    s_r    <= nxt_s;
                    wcnt_r <= wcnt_r + 16'd1;
                    if (wcnt_r == WU_LAST) begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_WARMUP;
                        busy_r  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (k_r != K_LAST) begin
                        s_r         <= nxt_s;
                        asm_r       <= beat_s;
                        k_r         <= k_r + KW'(1);
                        out_valid_r <= out_valid_r & ~out_ready;
                    end else if (!out_valid_r || out_ready) begin
                        // Final word completes a beat, possibly back-to-back with a transfer.
                        s_r         <= nxt_s;
                        out_data_r  <= beat_s;
                        out_valid_r <= 1'b1;
                        k_r         <= '0;
                    end else begin
                        s_r         <= s_r;
                        out_valid_r <= out_valid_r;
                    end
                end
                default: begin
                    state_r     <= ST_LOAD;
                    busy_r      <= (ST_LOAD == ST_WARMUP);
                    k_r         <= '0;
                    wcnt_r      <= 16'd0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_taus88_stream.sv
// Bench for taus88_stream: three instances (1 word/no warm-up, 2 words/no warm-up,
// 1 word/16 warm-up) driven in parallel and checked against a word-sequence model.
module tb_taus88_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        seed_valid;
    logic [95:0] seed_data;
    logic        out_ready;

    logic        a_valid, b_valid, c_valid;
    logic        a_busy, b_busy, c_busy;
    logic [31:0] a_data;
    logic [63:0] b_data;
    logic [31:0] c_data;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] ref_w [0:1023];

    always #5 clk = ~clk;

    taus88_stream #(.NUM_WORDS(1), .WARMUP(0)) dut_a (
        .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed_data(seed_data),
        .out_valid(a_valid), .out_ready(out_ready), .out_data(a_data), .busy(a_busy));

    taus88_stream #(.NUM_WORDS(2), .WARMUP(0)) dut_b (
        .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed_data(seed_data),
        .out_valid(b_valid), .out_ready(out_ready), .out_data(b_data), .busy(b_busy));

    taus88_stream #(.NUM_WORDS(1), .WARMUP(16)) dut_c (
        .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed_data(seed_data),
        .out_valid(c_valid), .out_ready(out_ready), .out_data(c_data), .busy(c_busy));

    // Reference: the raw word stream produced from a seed, one word per step.
    task automatic model_load(input logic [95:0] sd);
        logic [31:0] s1, s2, s3;
        s1 = sd[31:0];
        s2 = sd[63:32];
        s3 = sd[95:64];
        if (s1 < 32'd2)  s1 = s1 | 32'd2;
        if (s2 < 32'd8)  s2 = s2 | 32'd8;
        if (s3 < 32'd16) s3 = s3 | 32'd16;
        for (int i = 0; i < 1024; i++) begin
            s1 = ((s1 & 32'hFFFFFFFE) << 12) ^ (((s1 << 13) ^ s1) >> 19);
            s2 = ((s2 & 32'hFFFFFFF8) << 4)  ^ (((s2 << 2)  ^ s2) >> 25);
            s3 = ((s3 & 32'hFFFFFFF0) << 17) ^ (((s3 << 3)  ^ s3) >> 11);
            ref_w[i] = s1 ^ s2 ^ s3;
        end
    endtask

    // Beat j of an instance: words after the warm-up discards, first word lowest.
    function automatic logic [63:0] exp_beat(input int nw, input int wu, input int j);
        logic [63:0] r;
        r = 64'd0;
        for (int i = 0; i < nw; i++) begin
            r[32*i +: 32] = ref_w[wu + j*nw + i];
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [95:0] sd);
        seed_valid = 1'b1;
        seed_data  = sd;
        tick();
        seed_valid = 1'b0;
        model_load(sd);
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        seed_valid = 1'b0;
        seed_data  = 96'd0;
        out_ready  = 1'b0;
        tick();
        tick();
        vectors++;
        if ({a_valid, b_valid, c_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_valid got %b want 000", {a_valid, b_valid, c_valid});
        end
        vectors++;
        if ({a_busy, b_busy, c_busy} !== 3'b001) begin
            miscompares++;
            $display("FAIL reset_busy got %b want 001", {a_busy, b_busy, c_busy});
        end
        vectors++;
        if ({a_data, b_data, c_data} !== 128'd0) begin
            miscompares++;
            $display("FAIL reset_data got %h want 0", {a_data, b_data, c_data});
        end
        rst = 1'b0;
        model_load({32'hC0B4DD55, 32'hB4B4D15C, 32'hE761B9DB});
        out_ready = 1'b1;
        tick();
        vectors++;
        if (a_valid !== 1'b1 || a_data !== ref_w[0]) begin
            miscompares++;
            $display("FAIL reset_default_seq got %b/%h want 1/%h", a_valid, a_data, ref_w[0]);
        end
    endtask

    task automatic test_known_seed;
        out_ready = 1'b1;
        do_load({32'd16, 32'd8, 32'd2});
        vectors++;
        if ({a_valid, b_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL known_after_load got %b want 00", {a_valid, b_valid});
        end
        tick();
        vectors++;
        if (a_valid !== 1'b1 || a_data !== 32'h00202080 || b_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL known_first got a=%b/%h b=%b want 1/00202080 0", a_valid, a_data, b_valid);
        end
        tick();
        vectors++;
        if (a_valid !== 1'b1 || a_data !== 32'h02002C80) begin
            miscompares++;
            $display("FAIL known_second got %b/%h want 1/02002c80", a_valid, a_data);
        end
        vectors++;
        if (b_valid !== 1'b1 || b_data !== 64'h02002C80_00202080) begin
            miscompares++;
            $display("FAIL known_wide got %b/%h want 1/02002c8000202080", b_valid, b_data);
        end
    endtask

    task automatic test_zero_seed;
        out_ready = 1'b1;
        do_load(96'd0);
        tick();
        vectors++;
        if (a_valid !== 1'b1 || a_data !== 32'h00202080) begin
            miscompares++;
            $display("FAIL zero_seed got %b/%h want 1/00202080", a_valid, a_data);
        end
    endtask

    task automatic test_backpressure;
        logic [63:0] e;
        out_ready = 1'b0;
        do_load({$urandom, $urandom, $urandom});
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            e = exp_beat(1, 0, 0);
            vectors++;
            if (a_valid !== 1'b1 || a_data !== e[31:0]) begin
                miscompares++;
                $display("FAIL bp_hold_a cyc %0d got %b/%h want 1/%h", i, a_valid, a_data, e[31:0]);
            end
            e = exp_beat(2, 0, 0);
            vectors++;
            if (b_valid !== 1'b1 || b_data !== e) begin
                miscompares++;
                $display("FAIL bp_hold_b cyc %0d got %b/%h want 1/%h", i, b_valid, b_data, e);
            end
        end
        out_ready = 1'b1;
        tick();
        e = exp_beat(1, 0, 1);
        vectors++;
        if (a_valid !== 1'b1 || a_data !== e[31:0]) begin
            miscompares++;
            $display("FAIL bp_release_a got %b/%h want 1/%h", a_valid, a_data, e[31:0]);
        end
        e = exp_beat(2, 0, 1);
        vectors++;
        if (b_valid !== 1'b1 || b_data !== e) begin
            miscompares++;
            $display("FAIL bp_release_b got %b/%h want 1/%h", b_valid, b_data, e);
        end
    endtask

    task automatic test_warmup;
        logic [63:0] e;
        out_ready = 1'b1;
        do_load({$urandom, $urandom, $urandom});
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (c_busy !== 1'b1 || c_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL warmup_busy cyc %0d got busy=%b valid=%b want 1/0", i, c_busy, c_valid);
            end
            tick();
        end
        vectors++;
        if (c_busy !== 1'b0 || c_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL warmup_end got busy=%b valid=%b want 0/0", c_busy, c_valid);
        end
        tick();
        e = exp_beat(1, 16, 0);
        vectors++;
        if (c_valid !== 1'b1 || c_data !== e[31:0]) begin
            miscompares++;
            $display("FAIL warmup_first got %b/%h want 1/%h", c_valid, c_data, e[31:0]);
        end
    endtask

    task automatic test_random_stream;
        int bi_a, bi_b, bi_c;
        logic st_a, st_b, st_c;
        logic [31:0] h_a, h_c;
        logic [63:0] h_b, e;
        bi_a = 0; bi_b = 0; bi_c = 0;
        out_ready = 1'b1;
        do_load({$urandom, $urandom, $urandom});
        for (int cyc = 0; cyc < 400; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (a_valid && out_ready) begin
                e = exp_beat(1, 0, bi_a);
                vectors++;
                if (a_data !== e[31:0]) begin
                    miscompares++;
                    $display("FAIL stream_a beat %0d got %h want %h", bi_a, a_data, e[31:0]);
                end
                bi_a++;
            end
            if (b_valid && out_ready) begin
                e = exp_beat(2, 0, bi_b);
                vectors++;
                if (b_data !== e) begin
                    miscompares++;
                    $display("FAIL stream_b beat %0d got %h want %h", bi_b, b_data, e);
                end
                bi_b++;
            end
            if (c_valid && out_ready) begin
                e = exp_beat(1, 16, bi_c);
                vectors++;
                if (c_data !== e[31:0]) begin
                    miscompares++;
                    $display("FAIL stream_c beat %0d got %h want %h", bi_c, c_data, e[31:0]);
                end
                bi_c++;
            end
            st_a = a_valid && !out_ready; h_a = a_data;
            st_b = b_valid && !out_ready; h_b = b_data;
            st_c = c_valid && !out_ready; h_c = c_data;
            tick();
            if (st_a) begin
                vectors++;
                if (a_valid !== 1'b1 || a_data !== h_a) begin
                    miscompares++;
                    $display("FAIL stall_a got %b/%h want 1/%h", a_valid, a_data, h_a);
                end
            end
            if (st_b) begin
                vectors++;
                if (b_valid !== 1'b1 || b_data !== h_b) begin
                    miscompares++;
                    $display("FAIL stall_b got %b/%h want 1/%h", b_valid, b_data, h_b);
                end
            end
            if (st_c) begin
                vectors++;
                if (c_valid !== 1'b1 || c_data !== h_c) begin
                    miscompares++;
                    $display("FAIL stall_c got %b/%h want 1/%h", c_valid, c_data, h_c);
                end
            end
        end
        vectors++;
        if (bi_a < 150 || bi_b < 75 || bi_c < 100) begin
            miscompares++;
            $display("FAIL stream_progress got %0d/%0d/%0d beats want >=150/75/100", bi_a, bi_b, bi_c);
        end
    endtask

    task automatic test_load_midrun;
        logic [63:0] e;
        out_ready = 1'b1;
        do_load({$urandom, $urandom, $urandom});
        for (int i = 0; i < 5; i++) tick();
        vectors++;
        if (a_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midrun_pre got %b want 1", a_valid);
        end
        do_load({$urandom, $urandom, $urandom});
        vectors++;
        if ({a_valid, b_valid, c_valid, c_busy} !== 4'b0001) begin
            miscompares++;
            $display("FAIL midrun_load got %b want 0001", {a_valid, b_valid, c_valid, c_busy});
        end
        tick();
        e = exp_beat(1, 0, 0);
        vectors++;
        if (a_valid !== 1'b1 || a_data !== e[31:0] || b_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_restart_a got %b/%h b=%b want 1/%h 0", a_valid, a_data, b_valid, e[31:0]);
        end
        tick();
        e = exp_beat(2, 0, 0);
        vectors++;
        if (b_valid !== 1'b1 || b_data !== e) begin
            miscompares++;
            $display("FAIL midrun_restart_b got %b/%h want 1/%h", b_valid, b_data, e);
        end
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        vectors++;
        if ({a_valid, b_valid, c_valid, a_busy, b_busy, c_busy} !== 6'b000001 ||
            {a_data, b_data, c_data} !== 128'd0) begin
            miscompares++;
            $display("FAIL midrun_rst got %b/%h want 000001/0",
                     {a_valid, b_valid, c_valid, a_busy, b_busy, c_busy}, {a_data, b_data, c_data});
        end
        rst = 1'b0;
        model_load({32'hC0B4DD55, 32'hB4B4D15C, 32'hE761B9DB});
        tick();
        e = exp_beat(1, 0, 0);
        vectors++;
        if (a_valid !== 1'b1 || a_data !== e[31:0]) begin
            miscompares++;
            $display("FAIL midrun_rst_seq got %b/%h want 1/%h", a_valid, a_data, e[31:0]);
        end
    endtask

    initial begin
        rst        = 1'b1;
        seed_valid = 1'b0;
        seed_data  = 96'd0;
        out_ready  = 1'b0;
        test_reset();
        test_known_seed();
        test_zero_seed();
        test_backpressure();
        test_warmup();
        test_random_stream();
        test_load_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
